// File: rtl/fp_dot_accumulator_if.sv
//------------------------------------------------------------------------------
// fp_dot_accumulator_if : product-in / sum-out strobe-ack bus of the accumulator
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp_dot_accumulator_if;
   logic [31:0] input_p;
   logic        input_p_stb;
   logic        input_p_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   // master: the side that produces products and consumes sums
   modport master (
      output input_p, input_p_stb, output_z_ack,
      input  input_p_ack, output_z, output_z_stb
   );

   modport slave (
      input  input_p, input_p_stb, output_z_ack,
      output input_p_ack, output_z, output_z_stb
   );
endinterface

`default_nettype wire

// File: rtl/fp_dot_accumulator.sv
//------------------------------------------------------------------------------
// fp_dot_accumulator : sums LEN IEEE-754 single products (RNE) into one element.
// Option macro FP_ACC_FLUSH_DENORM_EN flushes denormals to signed zero. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_dot_accumulator #(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   fp_dot_accumulator_if.slave bus
);

   typedef enum logic [3:0] {
      c_get_p         = 4'd0,
      c_unpack        = 4'd1,
      c_special_cases = 4'd2,
      c_align         = 4'd3,
      c_add_0         = 4'd4,
      c_add_1         = 4'd5,
      c_normalise_1   = 4'd6,
      c_normalise_2   = 4'd7,
      c_round         = 4'd8,
      c_pack          = 4'd9,
      c_put_z         = 4'd10
   } state_t;

   localparam logic signed [9:0]  c_ezero = -10'sd127;
   localparam logic signed [9:0]  c_emin  = -10'sd126;
   localparam logic signed [9:0]  c_emax  = 10'sd127;
   localparam logic signed [9:0]  c_einf  = 10'sd128;
   localparam logic [31:0]        c_qnan  = 32'hFFC0_0000;
   localparam logic [CNT_W-1:0]   c_last  = CNT_W'(LEN - 1);

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_p, r_acc, r_out_z, r_spec_z;
   logic              r_p_ack, r_z_stb, r_special;
   logic [26:0]       r_a_m, r_b_m;
   logic signed [9:0] r_a_e, r_b_e, r_z_e;
   logic              r_a_s, r_b_s, r_z_s;
   logic [27:0]       r_sum;
   logic [23:0]       r_z_m;
   logic              r_guard, r_round, r_sticky;
   logic [CNT_W-1:0]  r_count;

   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic        w_special_hit, w_align_done, w_z_zero, w_norm1_go, w_norm2_go;
   logic        w_in_xfer, w_out_xfer;
   logic [31:0] w_spec_z, w_pack;

   assign bus.input_p_ack  = r_p_ack;
   assign bus.output_z     = r_out_z;
   assign bus.output_z_stb = r_z_stb;

   assign w_in_xfer  = r_p_ack && bus.input_p_stb;
   assign w_out_xfer = r_z_stb && bus.output_z_ack;

   // operand a is the running sum, operand b the freshly captured product
   assign w_a_nan = (r_a_e == c_einf) && (r_a_m != 27'd0);
   assign w_b_nan = (r_b_e == c_einf) && (r_b_m != 27'd0);
   assign w_a_inf = (r_a_e == c_einf) && (r_a_m == 27'd0);
   assign w_b_inf = (r_b_e == c_einf) && (r_b_m == 27'd0);
`ifdef FP_ACC_FLUSH_DENORM_EN
   assign w_a_zero = (r_a_e == c_ezero);
   assign w_b_zero = (r_b_e == c_ezero);
`else
   assign w_a_zero = (r_a_e == c_ezero) && (r_a_m == 27'd0);
   assign w_b_zero = (r_b_e == c_ezero) && (r_b_m == 27'd0);
`endif

   always_comb begin
      w_special_hit = 1'b1;
      w_spec_z      = 32'd0;
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a_s != r_b_s))) begin
         w_spec_z = c_qnan;
      end else if (w_a_inf) begin
         w_spec_z = {r_a_s, 8'hFF, 23'd0};
      end else if (w_b_inf) begin
         w_spec_z = {r_b_s, 8'hFF, 23'd0};
      end else if (w_a_zero && w_b_zero) begin
         w_spec_z = {r_a_s & r_b_s, 31'd0};
      end else if (w_a_zero) begin
         w_spec_z = r_p;
      end else if (w_b_zero) begin
         w_spec_z = r_acc;
      end else begin
         w_special_hit = 1'b0;
      end
   end

   assign w_align_done = (r_a_e == r_b_e);
   // an exactly cancelled sum skips the left-normalise walk down to emin
   assign w_z_zero     = (r_z_m == 24'd0) && !r_guard && !r_round;
   assign w_norm1_go   = !w_z_zero && !r_z_m[23] && (r_z_e > c_emin);
   assign w_norm2_go   = (r_z_e < c_emin);

   always_comb begin
      w_pack = {r_z_s, 8'(r_z_e + 10'sd127), r_z_m[22:0]};
`ifdef FP_ACC_FLUSH_DENORM_EN
      if ((r_z_e < c_emin) || ((r_z_e == c_emin) && !r_z_m[23])) begin
         w_pack = {r_z_s, 31'd0};
      end
`else
      if ((r_z_e == c_emin) && !r_z_m[23]) begin
         w_pack[30:23] = 8'd0;
      end
`endif
      if (r_z_e > c_emax) begin
         w_pack = {r_z_s, 8'hFF, 23'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_get_p;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         c_get_p:         if (w_in_xfer) w_state_nxt = c_unpack;
         c_unpack:        w_state_nxt = c_special_cases;
         c_special_cases: w_state_nxt = w_special_hit ? c_pack : c_align;
         c_align:         if (w_align_done) w_state_nxt = c_add_0;
         c_add_0:         w_state_nxt = c_add_1;
         c_add_1:         w_state_nxt = c_normalise_1;
`ifdef FP_ACC_FLUSH_DENORM_EN
         c_normalise_1:   if (!w_norm1_go) w_state_nxt = c_round;
`else
         c_normalise_1:   if (!w_norm1_go) w_state_nxt = c_normalise_2;
`endif
         c_normalise_2:   if (!w_norm2_go) w_state_nxt = c_round;
         c_round:         w_state_nxt = c_pack;
         c_pack:          w_state_nxt = (r_count == c_last) ? c_put_z : c_get_p;
         c_put_z:         if (w_out_xfer) w_state_nxt = c_get_p;
         default:         w_state_nxt = c_get_p;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p       <= 32'd0;
         r_acc     <= 32'd0;
         r_out_z   <= 32'd0;
         r_spec_z  <= 32'd0;
         r_p_ack   <= 1'b0;
         r_z_stb   <= 1'b0;
         r_special <= 1'b0;
         r_a_m     <= 27'd0;
         r_b_m     <= 27'd0;
         r_a_e     <= 10'sd0;
         r_b_e     <= 10'sd0;
         r_z_e     <= 10'sd0;
         r_a_s     <= 1'b0;
         r_b_s     <= 1'b0;
         r_z_s     <= 1'b0;
         r_sum     <= 28'd0;
         r_z_m     <= 24'd0;
         r_guard   <= 1'b0;
         r_round   <= 1'b0;
         r_sticky  <= 1'b0;
         r_count   <= '0;
      end else begin
         unique case (r_state)
            c_get_p: begin
               r_p_ack <= 1'b1;
               if (w_in_xfer) begin
                  r_p     <= bus.input_p;
                  r_p_ack <= 1'b0;
               end
            end
            c_unpack: begin
               r_a_m <= {r_acc[22:0], 3'd0};
               r_b_m <= {r_p[22:0], 3'd0};
               r_a_e <= $signed({2'b00, r_acc[30:23]}) - 10'sd127;
               r_b_e <= $signed({2'b00, r_p[30:23]}) - 10'sd127;
               r_a_s <= r_acc[31];
               r_b_s <= r_p[31];
            end
            c_special_cases: begin
               r_special <= w_special_hit;
               r_spec_z  <= w_spec_z;
               if (!w_special_hit) begin
                  if (r_a_e == c_ezero) r_a_e <= c_emin;
                  else                  r_a_m[26] <= 1'b1;
                  if (r_b_e == c_ezero) r_b_e <= c_emin;
                  else                  r_b_m[26] <= 1'b1;
               end
            end
            c_align: begin
               // bit 0 doubles as sticky, so bits falling off are ORed into it
               if (r_a_e > r_b_e) begin
                  r_b_e <= r_b_e + 10'sd1;
                  r_b_m <= {1'b0, r_b_m[26:1]} | {26'd0, r_b_m[0]};
               end else if (r_a_e < r_b_e) begin
                  r_a_e <= r_a_e + 10'sd1;
                  r_a_m <= {1'b0, r_a_m[26:1]} | {26'd0, r_a_m[0]};
               end
            end
            c_add_0: begin
               r_z_e <= r_a_e;
               if (r_a_s == r_b_s) begin
                  r_sum <= {1'b0, r_a_m} + {1'b0, r_b_m};
                  r_z_s <= r_a_s;
               end else if (r_a_m > r_b_m) begin
                  r_sum <= {1'b0, r_a_m} - {1'b0, r_b_m};
                  r_z_s <= r_a_s;
               end else if (r_a_m < r_b_m) begin
                  r_sum <= {1'b0, r_b_m} - {1'b0, r_a_m};
                  r_z_s <= r_b_s;
               end else begin
                  r_sum <= 28'd0;
                  r_z_s <= 1'b0;
               end
            end
            c_add_1: begin
               if (r_sum[27]) begin
                  r_z_m    <= r_sum[27:4];
                  r_guard  <= r_sum[3];
                  r_round  <= r_sum[2];
                  r_sticky <= r_sum[1] | r_sum[0];
                  r_z_e    <= r_z_e + 10'sd1;
               end else begin
                  r_z_m    <= r_sum[26:3];
                  r_guard  <= r_sum[2];
                  r_round  <= r_sum[1];
                  r_sticky <= r_sum[0];
               end
            end
            c_normalise_1: begin
               if (w_z_zero) begin
                  r_z_e <= c_emin;
               end else if (w_norm1_go) begin
                  r_z_e   <= r_z_e - 10'sd1;
                  r_z_m   <= {r_z_m[22:0], r_guard};
                  r_guard <= r_round;
                  r_round <= 1'b0;
               end
            end
            c_normalise_2: begin
               if (w_norm2_go) begin
                  r_z_e    <= r_z_e + 10'sd1;
                  r_z_m    <= {1'b0, r_z_m[23:1]};
                  r_guard  <= r_z_m[0];
                  r_round  <= r_guard;
                  r_sticky <= r_sticky | r_round;
               end
            end
            c_round: begin
               if (r_guard && (r_round || r_sticky || r_z_m[0])) begin
                  r_z_m <= r_z_m + 24'd1;
                  if (r_z_m == 24'hFF_FFFF) r_z_e <= r_z_e + 10'sd1;
               end
            end
            c_pack: begin
               r_acc   <= r_special ? r_spec_z : w_pack;
               r_count <= r_count + 1'b1;
            end
            c_put_z: begin
               r_out_z <= r_acc;
               r_z_stb <= 1'b1;
               if (w_out_xfer) begin
                  r_z_stb <= 1'b0;
                  r_acc   <= 32'd0;
                  r_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
